arbiter_rr: RTL and testbench
=============================

# arbiter_rr

Parametrised N-channel memory arbiter that sits between several bus masters (CPU, PPU, APU DMA, …) and a single shared memory port. It supports a run-time selectable fixed-priority or round-robin grant policy. It keeps one outstanding request on the memory side and routes read-data returns, which may come back out of order, to the tagged requester by ID. An optional lock feature lets a master keep the grant across consecutive requests.

## Interface
Parameters:
- `AN`, 16: address width.
- `DN`, 8: data width.
- `NCH`, 4: number of requester channels, 2..16, not restricted to a power of two.
- `IDW`, `$clog2(NCH)`: ID width; the minimum is 1.

Ports:
- `clkSYS`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  1  grant policy. 0 = fixed priority, channel 0 highest. 1 = round-robin.
- `req`  in  NCH  per-channel request.
- `wr`  in  NCH  per-channel write flag.
- `addr`  in  NCH*AN  per-channel address, packed; channel i occupies `[i*AN +: AN]`.
- `data`  in  NCH*DN  per-channel write data, packed the same way.
- `lock`  in  NCH  per-channel grant lock. This port exists only with `ARBITER_RR_LOCK_EN`.
- `ack`  out  NCH  one-cycle pulse to the granted channel when its request has been accepted.
- `valid`  out  NCH  one-cycle pulse when read data for that channel is on `rdata`.
- `rdata`  out  DN  registered read data, shared by all channels.
- `mem_req`, `mem_wr`  out  1  memory request and write flag.
- `mem_addr`  out  AN  memory address.
- `mem_data`  out  DN  memory write data.
- `mem_id`  out  IDW  ID of the granted channel.
- `mem_ack`  in  1  memory accepted the current request.
- `mem_valid`  in  1  read data is returning.
- `mem_rdata`  in  DN  returning read data.
- `mem_rid`  in  IDW  ID tag for `mem_rdata`.

## Operation
- **FSM states:** IDLE, REQ, HOLD.
  - IDLE → REQ when any `req` bit is set. In the same edge, register `mem_req`=1 and the winner's `addr`/`data`/`wr`/ID into `mem_*`.
  - REQ → HOLD on `mem_ack`=1. In that edge: `mem_req`←0, `ack[mem_id]`←1, and the remaining `mem_*` outputs hold their value.
  - HOLD → IDLE unconditionally, except for the lock case described under Configuration.
- **Fixed-priority mode:** the winner is the lowest-index channel with `req` set.
- **Round-robin mode:** the winner is the first channel with `req` set, searching upward from `ptr` with wrap-around modulo NCH.
  - `ptr` ← (granted ID + 1) mod NCH on each `mem_ack`. The wrap must be correct for non-power-of-two NCH, e.g. NCH=3 goes 2→0.
  - `ptr` is maintained in both modes, so switching `mode` takes effect at the next IDLE decision with no glitch.
- **`mode` sampling:** `mode` is sampled only in IDLE. Changing it during REQ or HOLD has no effect on the transaction in flight.
- **Requester rule:** a requester holds `req` and its payload stable until it samples `ack`=1, then drops `req` at that same edge. The HOLD cycle guarantees the stale `req` is never re-arbitrated.
- **Read return path:** independent of the FSM.
  - On `mem_valid`: `valid[mem_rid]`←1 and `rdata`←`mem_rdata`, both on the next edge.
  - Other `valid` bits are 0. `rdata` holds its value when `mem_valid`=0.
  - `mem_rid` ≥ NCH produces no `valid` pulse.
- **Simultaneous events:** `mem_valid` coinciding with `mem_ack`, or a new `req` during REQ/HOLD, are legal. New requests wait for IDLE.
- **Reset mid-transaction:** the FSM returns to IDLE, any in-flight `ack` is dropped, and pending reads are lost. The memory side must be reset together with the arbiter.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `mem_req`=0, `mem_wr`=0, `mem_addr`=0, `mem_data`=0, `mem_id`=0, `ack`=0, `valid`=0, `rdata`=0.
- **Request to memory:** `req` seen in cycle t gives `mem_req`=1 in cycle t+1.
- **Ack latency:** `mem_ack` seen in cycle k gives `ack` pulse and `mem_req`=0 in cycle k+1, HOLD in k+1, and IDLE in k+2.
- **Earliest next grant:** `mem_req` can rise again in cycle k+3.
- **Minimum cycle:** 3 cycles per transaction when `mem_ack` returns in the first REQ cycle.
- **Read data latency:** 1 cycle from `mem_valid` to `valid`/`rdata`.

## Configuration
- **Macro `ARBITER_RR_LOCK_EN` defined:** the `lock` port exists.
  - If `lock[mem_id]`=1 at the `mem_ack` edge, `ptr` is not advanced.
  - At the exit from HOLD, if that channel's `req`=1, the FSM goes directly to REQ with that channel regardless of `mode`. Its new payload is sampled at that edge.
  - Otherwise the FSM goes to IDLE as normal.
- **Macro not defined:** there is no `lock` port and behaviour is exactly as described in Operation.

## Test plan
- **Reset:** assert `reset` mid-REQ → next cycle every output is at its reset value; after release with no `req`, `mem_req` stays 0.
- **Fixed priority:** `mode`=0, `req`=4'b1010 held, memory acks immediately → grants go 1, 1, 1 while ch1 re-requests; drop ch1 → ch3 is granted. Each `ack` is one cycle, three cycles apart.
- **Round-robin with non-power-of-two NCH:** NCH=3, `mode`=1, all channels requesting continuously → `mem_id` sequence 0, 1, 2, 0, 1; `ptr` wraps 2→0.
- **Out-of-order read return:** `mem_valid` with `mem_rid`=2, `mem_rdata`=8'hA5, then `mem_rid`=0, `mem_rdata`=8'h3C → `valid`=4'b0100 with `rdata`=A5, then `valid`=4'b0001 with `rdata`=3C. Repeat with one return coinciding with a `mem_ack`; the routing must be unaffected.
- **Lock (`ARBITER_RR_LOCK_EN`):** `mode`=1, ch0 has `lock`=1 and 3 back-to-back requests, ch1 requesting → ch0 is granted 3 times, then ch1 is granted.
- **Delayed ack:** `mem_ack` arrives 5 cycles after `mem_req` → `mem_addr`/`mem_data`/`mem_id` stay stable for all 5 cycles and exactly one `ack` pulse is produced.

Source files
------------

// File: rtl/arbiter_rr.sv
`default_nettype none
// arbiter_rr: N-channel memory arbiter, fixed-priority or round-robin grant, one outstanding request.
// Optional grant lock enabled by defining ARBITER_RR_LOCK_EN (adds the lock port).
module arbiter_rr #(
  parameter int AN  = 16,
  parameter int DN  = 8,
  parameter int NCH = 4,
  parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clkSYS,
  input  logic              reset,
  input  logic              mode,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    wr,
  input  logic [NCH*AN-1:0] addr,
  input  logic [NCH*DN-1:0] data,
`ifdef ARBITER_RR_LOCK_EN
  input  logic [NCH-1:0]    lock,
`endif
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    valid,
  output logic [DN-1:0]     rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [AN-1:0]     mem_addr,
  output logic [DN-1:0]     mem_data,
  output logic [IDW-1:0]    mem_id,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [DN-1:0]     mem_rdata,
  input  logic [IDW-1:0]    mem_rid
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic             locked;

  logic [2*NCH-1:0] req2;
  logic [NCH-1:0]   rot;
  logic [IDW-1:0]   rr_off;
  logic [IDW:0]     rr_sum;
  logic [IDW-1:0]   fp_id;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   sel_id;
  logic [IDW-1:0]   ptr_inc;
  logic             lock_now;

`ifdef ARBITER_RR_LOCK_EN
  assign lock_now = lock[mem_id];
`else
  assign lock_now = 1'b0;
`endif

  // Round-robin: rotate the doubled request vector so bit 0 is the channel at ptr.
  always_comb begin
    req2   = {req, req};
    rot    = NCH'(req2 >> ptr);
    rr_off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = IDW'(i);
    end
    rr_sum = {1'b0, ptr} + {1'b0, rr_off};
    if (rr_sum >= (IDW+1)'(NCH)) rr_sum = rr_sum - (IDW+1)'(NCH);
    fp_id = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) fp_id = IDW'(i);
    end
    win_id  = mode ? rr_sum[IDW-1:0] : fp_id;
    sel_id  = (state == HOLD) ? mem_id : win_id;
    ptr_inc = (mem_id == IDW'(NCH - 1)) ? '0 : mem_id + 1'b1;
  end

  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      locked   <= 1'b0;
      ack      <= '0;
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_id   <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_wr   <= wr[sel_id];
            mem_addr <= addr[sel_id*AN +: AN];
            mem_data <= data[sel_id*DN +: DN];
            mem_id   <= sel_id;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state       <= HOLD;
            mem_req     <= 1'b0;
            ack[mem_id] <= 1'b1;
            locked      <= lock_now;
            if (!lock_now) ptr <= ptr_inc;
          end
        end
        HOLD: begin
          // The requester's req is still the stale one here unless it holds the lock.
          if (locked && req[mem_id]) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_wr   <= wr[sel_id];
            mem_addr <= addr[sel_id*AN +: AN];
            mem_data <= data[sel_id*DN +: DN];
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read return routing runs independently of the request FSM.
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      valid <= '0;
      rdata <= '0;
    end else begin
      valid <= '0;
      if (mem_valid) begin
        rdata <= mem_rdata;
        if ({1'b0, mem_rid} < (IDW+1)'(NCH)) valid[mem_rid] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr.sv
`default_nettype none
// tb_arbiter_rr: directed and randomized stimulus checked against a transaction-level model.
module tb_arbiter_rr;
  localparam int NCH = 5;
  localparam int AN  = 16;
  localparam int DN  = 8;
  localparam int IDW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, mode, mem_ack, mem_valid;
  logic [NCH-1:0]    req, wr, lock;
  logic [NCH*AN-1:0] addr;
  logic [NCH*DN-1:0] data;
  logic [DN-1:0]     mem_rdata;
  logic [IDW-1:0]    mem_rid;
  logic [NCH-1:0]    ack, valid;
  logic [DN-1:0]     rdata, mem_data;
  logic              mem_req, mem_wr;
  logic [AN-1:0]     mem_addr;
  logic [IDW-1:0]    mem_id;

  arbiter_rr #(.AN(AN), .DN(DN), .NCH(NCH), .IDW(IDW)) dut (
    .clkSYS(clk), .reset(reset), .mode(mode), .req(req), .wr(wr), .addr(addr), .data(data),
`ifdef ARBITER_RR_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .valid(valid), .rdata(rdata), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_id(mem_id), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_rid(mem_rid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: one outstanding grant, a free edge index, rotating pointer.
  bit  m_busy, m_relock;
  int  m_w, m_ptr, m_edge, m_free;
  logic           e_mem_req, e_mem_wr;
  logic [AN-1:0]  e_mem_addr;
  logic [DN-1:0]  e_mem_data, e_rdata;
  logic [IDW-1:0] e_mem_id;
  logic [NCH-1:0] e_ack, e_valid;

  // Requester / memory drivers
  int rem [NCH];
  bit stale [NCH];
  int busy_cyc, ack_delay;
  int gq[$];
  int gt[$];
  int exp_ids[4];

  function automatic bit lock_at(int i);
`ifdef ARBITER_RR_LOCK_EN
    return lock[i];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int pick();
    if (!mode) begin
      for (int i = 0; i < NCH; i++) if (req[i]) return i;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (req[c]) return c;
      end
    end
    return 0;
  endfunction

  task automatic model_edge();
    bit granted;
    int w;
    granted = 1'b0;
    w = 0;
    if (reset) begin
      m_busy = 1'b0; m_relock = 1'b0; m_ptr = 0; m_free = m_edge + 1;
      e_mem_req = 1'b0; e_mem_wr = 1'b0; e_mem_addr = '0; e_mem_data = '0; e_mem_id = '0;
      e_ack = '0; e_valid = '0; e_rdata = '0;
    end else begin
      e_ack = '0;
      e_valid = '0;
      if (mem_valid) begin
        e_rdata = mem_rdata;
        if (int'(mem_rid) < NCH) e_valid[mem_rid] = 1'b1;
      end
      if (m_busy) begin
        if (mem_ack) begin
          e_mem_req = 1'b0;
          e_ack[m_w] = 1'b1;
          m_busy = 1'b0;
          m_free = m_edge + 2;
          m_relock = lock_at(m_w);
          if (!m_relock) m_ptr = (m_w + 1) % NCH;
        end
      end else if (m_relock && m_edge == m_free - 1) begin
        if (req[m_w]) begin granted = 1'b1; w = m_w; end
      end else if (m_edge >= m_free && req != '0) begin
        granted = 1'b1;
        w = pick();
      end
      if (granted) begin
        m_busy = 1'b1; m_w = w;
        e_mem_req = 1'b1; e_mem_wr = wr[w];
        e_mem_addr = addr[w*AN +: AN]; e_mem_data = data[w*DN +: DN]; e_mem_id = IDW'(w);
      end
    end
    m_edge++;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("mem_req", 32'(mem_req), 32'(e_mem_req));
    chk("mem_wr", 32'(mem_wr), 32'(e_mem_wr));
    chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    chk("mem_data", 32'(mem_data), 32'(e_mem_data));
    chk("mem_id", 32'(mem_id), 32'(e_mem_id));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    for (int i = 0; i < NCH; i++) begin
      if (ack[i]) begin gq.push_back(i); gt.push_back(m_edge); end
    end
  endtask

  task automatic new_payload(int i);
    wr[i] = 1'($urandom);
    addr[i*AN +: AN] = AN'($urandom);
    data[i*DN +: DN] = DN'($urandom);
  endtask

  task automatic drive(bit rnd);
    for (int i = 0; i < NCH; i++) begin
      if (stale[i]) begin stale[i] = 1'b0; req[i] = 1'b0; end
      if (e_ack[i]) begin
        if (lock_at(i)) begin
          if (rem[i] > 0) begin rem[i]--; new_payload(i); end
          else req[i] = 1'b0;
        end else begin
          stale[i] = 1'b1;
        end
      end else if (!req[i] && rem[i] > 0) begin
        rem[i]--; req[i] = 1'b1; new_payload(i);
      end
      if (rnd && rem[i] == 0 && $urandom_range(7) == 0) rem[i] = 1 + $urandom_range(2);
    end
    if (m_busy) busy_cyc++; else busy_cyc = 0;
    mem_ack = m_busy && (rnd ? ($urandom_range(2) == 0) : (busy_cyc >= ack_delay));
    if (rnd) begin
      mode      = 1'($urandom);
      lock      = NCH'($urandom) & NCH'($urandom);
      mem_valid = ($urandom_range(2) == 0);
      mem_rid   = IDW'($urandom);
      mem_rdata = DN'($urandom);
      reset     = ($urandom_range(63) == 0);
    end
  endtask

  task automatic clear_all();
    reset = 1'b1; req = '0; lock = '0; mem_ack = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin rem[i] = 0; stale[i] = 1'b0; end
    step();
    reset = 1'b0;
    gq.delete(); gt.delete();
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; req = '0; wr = '0; lock = '0; addr = '0; data = '0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = '0; mem_rid = '0;
    m_edge = 0; m_free = 0; m_busy = 1'b0; m_relock = 1'b0; m_ptr = 0; m_w = 0;
    busy_cyc = 0; ack_delay = 1;
    for (int i = 0; i < NCH; i++) begin rem[i] = 0; stale[i] = 1'b0; end
    @(negedge clk);
    clear_all();
    step();

    // Fixed priority: ch1 asks three times, ch3 waits behind it.
    mode = 1'b0; req[1] = 1'b1; req[3] = 1'b1; new_payload(1); new_payload(3); rem[1] = 2;
    repeat (16) begin step(); drive(1'b0); end
    exp_ids = '{1, 1, 1, 3};
    chk("fp_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("fp_id", 32'(gq[i]), 32'(exp_ids[i]));
    for (int i = 1; i < gq.size(); i++) chk("fp_gap", 32'(gt[i] - gt[i-1]), 32'd3);

    // Out-of-order read returns and an out-of-range tag.
    clear_all();
    mem_valid = 1'b1; mem_rid = 3'd2; mem_rdata = 8'hA5; step();
    chk("ooo_valid_a", 32'(valid), 32'b00100); chk("ooo_rdata_a", 32'(rdata), 32'hA5);
    mem_rid = 3'd0; mem_rdata = 8'h3C; step();
    chk("ooo_valid_b", 32'(valid), 32'b00001); chk("ooo_rdata_b", 32'(rdata), 32'h3C);
    mem_rid = 3'd6; mem_rdata = 8'h77; step();
    chk("rid_oob_valid", 32'(valid), 32'd0); chk("rid_oob_rdata", 32'(rdata), 32'h77);
    mem_valid = 1'b0; step();
    chk("rdata_hold", 32'(rdata), 32'h77);

    // Delayed ack with a read return landing on the ack edge.
    mode = 1'b1; ack_delay = 5; req[2] = 1'b1; new_payload(2);
    repeat (12) begin
      step(); drive(1'b0);
      mem_valid = mem_ack; mem_rid = 3'd4; mem_rdata = 8'h5A;
    end
    chk("delay_acks", 32'(gq.size()), 32'd1);

    // Reset in the middle of a request.
    clear_all();
    ack_delay = 100; req[0] = 1'b1; new_payload(0);
    step(); drive(1'b0); step(); drive(1'b0);
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1; step();
    chk("rst_mem_req", 32'(mem_req), 32'd0); chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0; req = '0; mem_ack = 1'b0;
    repeat (3) step();
    chk("idle_mem_req", 32'(mem_req), 32'd0);
    ack_delay = 1;

`ifdef ARBITER_RR_LOCK_EN
    // Locked channel keeps the grant for three back-to-back requests.
    clear_all();
    mode = 1'b1; lock[0] = 1'b1; req[0] = 1'b1; req[1] = 1'b1; rem[0] = 2;
    new_payload(0); new_payload(1);
    repeat (16) begin step(); drive(1'b0); end
    exp_ids = '{0, 0, 0, 1};
    chk("lock_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("lock_id", 32'(gq[i]), 32'(exp_ids[i]));
    lock = '0;
`endif

    // Randomized traffic, mode/lock toggling, sporadic resets.
    clear_all();
    repeat (3000) begin step(); drive(1'b1); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
